yolo_job_sched: RTL and testbench



---
 rtl/yolo_job_sched_if.sv | 52 +++++
 rtl/yolo_job_sched.sv | 111 +++++++++++
 tb/tb_yolo_job_sched.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/yolo_job_sched_if.sv
// yolo_job_sched_if: stream-side bundle of the job sequencer.
//   isif_*  : head of the input-stream FIFO (data/strb/last/empty_n in, read out)
//   core_*  : valid/ready word channels into and out of yolo_core
//   osif_*  : output-stream FIFO write port (data/strb/last/user/write out, full_n in)
// modport master : the sequencer side
// modport slave  : the environment side (FIFOs + core)
interface yolo_job_sched_if #(
    parameter int TBITS = 64,
    parameter int TBYTE = 8
);
    logic [TBITS-1:0] isif_data_dout;
    logic [TBYTE-1:0] isif_strb_dout;
    logic             isif_last_dout;
    logic             isif_empty_n;
    logic             isif_read;

    logic             core_in_valid;
    logic             core_in_ready;
    logic [TBITS-1:0] core_in_data;
    logic             core_out_valid;
    logic             core_out_ready;
    logic [TBITS-1:0] core_out_data;

    logic [TBITS-1:0] osif_data_din;
    logic [TBYTE-1:0] osif_strb_din;
    logic             osif_last_din;
    logic             osif_user_din;
    logic             osif_full_n;
    logic             osif_write;

    modport master (
        input  isif_data_dout, isif_strb_dout, isif_last_dout, isif_empty_n,
        output isif_read,
        output core_in_valid, core_in_data,
        input  core_in_ready,
        input  core_out_valid, core_out_data,
        output core_out_ready,
        output osif_data_din, osif_strb_din, osif_last_din, osif_user_din, osif_write,
        input  osif_full_n
    );

    modport slave (
        output isif_data_dout, isif_strb_dout, isif_last_dout, isif_empty_n,
        input  isif_read,
        input  core_in_valid, core_in_data,
        output core_in_ready,
        output core_out_valid, core_out_data,
        input  core_out_ready,
        input  osif_data_din, osif_strb_din, osif_last_din, osif_user_din, osif_write,
        output osif_full_n
    );
endinterface

// File: rtl/yolo_job_sched.sv
// yolo_job_sched: job-level sequencer between the stream FIFOs and yolo_core.
// A start in IDLE latches input/output beat counts; words are then gated
// combinationally isif -> core and core -> osif until both counts complete,
// after which done pulses for one cycle.
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   start                  launch job (sampled only in IDLE)
//   cfg_in_words/out_words beat counts, latched on accepted start
//   busy, done, err_len    status: RUN|DONE, one-cycle done pulse, sticky framing error
//   s                      stream bundle (isif/core/osif), master side
module yolo_job_sched #(
    parameter int TBITS = 64,
    parameter int TBYTE = 8,
    parameter int CNTW  = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   start,
    input  logic [CNTW-1:0]        cfg_in_words,
    input  logic [CNTW-1:0]        cfg_out_words,
    output logic                   busy,
    output logic                   done,
    output logic                   err_len,
    yolo_job_sched_if.master       s
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [CNTW-1:0] in_len, out_len, in_cnt, out_cnt;
    logic [CNTW-1:0] in_cnt_nxt, out_cnt_nxt;
    logic            in_act, out_act, frame_bad;
    logic [TBITS-1:0] in_word, out_word;
    logic [TBYTE-1:0] strb_unused;

    assign strb_unused = s.isif_strb_dout;

    always_comb begin
        in_act  = (state == RUN) && (in_cnt < in_len);
        out_act = (state == RUN) && (out_cnt < out_len);
        in_word  = s.isif_data_dout;
        out_word = s.core_out_data;

        s.core_in_valid  = in_act && s.isif_empty_n;
        s.isif_read      = s.core_in_valid && s.core_in_ready;
        s.core_in_data   = in_word;

        s.core_out_ready = out_act && s.osif_full_n;
        s.osif_write     = s.core_out_ready && s.core_out_valid;
        s.osif_data_din  = out_word;
        s.osif_user_din  = (out_cnt == '0);
        s.osif_last_din  = (out_cnt == out_len - CNTW'(1));
        s.osif_strb_din  = '1;

        in_cnt_nxt  = in_cnt + CNTW'(s.isif_read);
        out_cnt_nxt = out_cnt + CNTW'(s.osif_write);

        // TLAST must coincide exactly with the final counted beat.
        frame_bad = s.isif_last_dout ? (in_cnt != in_len - CNTW'(1))
                                     : (in_cnt == in_len - CNTW'(1));
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= IDLE;
            in_len  <= '0;
            out_len <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            err_len <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        in_len  <= cfg_in_words;
                        out_len <= cfg_out_words;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                        err_len <= 1'b0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    in_cnt  <= in_cnt_nxt;
                    out_cnt <= out_cnt_nxt;
                    if (s.isif_read && frame_bad)
                        err_len <= 1'b1;
                    // Completion looks through this cycle's transfers so the
                    // final beat in cycle K yields DONE in K+1.
                    if (in_cnt_nxt == in_len && out_cnt_nxt == out_len) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_yolo_job_sched.sv
// Self-checking bench for yolo_job_sched: FIFO/core models driven from queues,
// expected output beats pushed to a scoreboard at stimulus time and popped on
// every osif_write.
module tb_yolo_job_sched;
    localparam int TBITS = 64;
    localparam int TBYTE = 8;
    localparam int CNTW  = 16;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic            start = 1'b0;
    logic [CNTW-1:0] cfg_in_words = '0;
    logic [CNTW-1:0] cfg_out_words = '0;
    logic            busy, done, err_len;

    yolo_job_sched_if #(.TBITS(TBITS), .TBYTE(TBYTE)) bus ();

    yolo_job_sched #(.TBITS(TBITS), .TBYTE(TBYTE), .CNTW(CNTW)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .start         (start),
        .cfg_in_words  (cfg_in_words),
        .cfg_out_words (cfg_out_words),
        .busy          (busy),
        .done          (done),
        .err_len       (err_len),
        .s             (bus)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [63:0] data;
        logic        user;
        logic        last;
    } exp_t;

    exp_t        expq[$];
    logic [63:0] fifo_d[$];
    logic        fifo_l[$];
    logic [63:0] core_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int          cur_in, grp, g_cnt, rd_cnt, wr_cnt, done_cnt, busy_cnt;
    int          last_wr_cyc, done_cyc, abort_after;
    logic [63:0] acc;
    logic        stall, hold, err_model, err_chk, done_seen, abort_now;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        exp_t e;
        @(negedge aclk);
        cyc++;
        if (err_chk) check("err_len", 64'(err_len), 64'(err_model));
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_seen = 1'b1;
        end
        if (bus.isif_read) begin
            if (fifo_d.size() == 0) begin
                check("read_empty_fifo", 64'd1, 64'd0);
            end else begin
                check("core_in_data", bus.core_in_data, fifo_d[0]);
                if ((fifo_l[0] && rd_cnt != cur_in - 1) || (!fifo_l[0] && rd_cnt == cur_in - 1))
                    err_model = 1'b1;
                acc += fifo_d[0];
                g_cnt++;
                if (g_cnt == grp) begin
                    core_q.push_back(acc);
                    acc   = '0;
                    g_cnt = 0;
                end
                void'(fifo_d.pop_front());
                void'(fifo_l.pop_front());
            end
            rd_cnt++;
            if (abort_after != 0 && rd_cnt == abort_after) abort_now = 1'b1;
        end
        if (bus.osif_write) begin
            check("write_full_n", 64'(bus.osif_full_n), 64'd1);
            check("strb", 64'(bus.osif_strb_din), 64'hFF);
            if (expq.size() == 0) begin
                check("extra_write", 64'd1, 64'd0);
            end else begin
                e = expq.pop_front();
                check("out_data", bus.osif_data_din, e.data);
                check("out_user", 64'(bus.osif_user_din), 64'(e.user));
                check("out_last", 64'(bus.osif_last_din), 64'(e.last));
            end
            if (core_q.size() > 0) void'(core_q.pop_front());
            wr_cnt++;
            last_wr_cyc = cyc;
        end
    endtask

    function automatic logic rbit(input logic en);
        return en ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    task automatic drive();
        @(posedge aclk);
        #1;
        start         = hold && !done_seen;
        cfg_in_words  = CNTW'($urandom);
        cfg_out_words = CNTW'($urandom);
        bus.isif_empty_n   = (fifo_d.size() > 0) && rbit(stall);
        bus.isif_data_dout = (fifo_d.size() > 0) ? fifo_d[0] : {$urandom, $urandom};
        bus.isif_last_dout = (fifo_l.size() > 0) ? fifo_l[0] : 1'($urandom_range(0, 1));
        bus.isif_strb_dout = TBYTE'($urandom);
        bus.core_in_ready  = rbit(stall);
        bus.core_out_valid = (core_q.size() > 0) && rbit(stall);
        bus.core_out_data  = (core_q.size() > 0) ? core_q[0] : {$urandom, $urandom};
        bus.osif_full_n    = rbit(stall);
    endtask

    task automatic tick();
        sample();
        drive();
    endtask

    task automatic run_job(input int in_n, input int out_n, input int g, input int last_pos,
                           input logic st, input logic hd, input logic exp_err,
                           input int exp_busy, input logic chk_t, input int ab);
        logic [63:0] w, gsum;
        int outs, n;
        exp_t e;
        stall = st; hold = hd; grp = g; cur_in = in_n; abort_after = ab; abort_now = 1'b0;
        acc = '0; g_cnt = 0; rd_cnt = 0; wr_cnt = 0; done_cnt = 0; busy_cnt = 0;
        done_seen = 1'b0; last_wr_cyc = 0; done_cyc = 0;
        gsum = '0; outs = 0;
        for (int i = 0; i < in_n; i++) begin
            w = {$urandom, $urandom};
            fifo_d.push_back(w);
            fifo_l.push_back((last_pos < 0) ? (i == in_n - 1) : (i == last_pos));
            gsum += w;
            if ((i + 1) % g == 0) begin
                if (outs < out_n) begin
                    e.data = gsum;
                    e.user = (outs == 0);
                    e.last = (outs == out_n - 1);
                    expq.push_back(e);
                end
                outs++;
                gsum = '0;
            end
        end
        err_chk = 1'b0;
        err_model = 1'b0;
        cfg_in_words  = CNTW'(in_n);
        cfg_out_words = CNTW'(out_n);
        start = 1'b1;
        tick();
        err_chk = 1'b1;
        n = 0;
        while (!done_seen && !abort_now && n < 2000) begin
            tick();
            n++;
        end
        if (abort_now) begin
            #2;
            aresetn = 1'b0;
            #1;
            check("reset_outputs", 64'({busy, done, err_len, bus.isif_read, bus.core_in_valid,
                                        bus.core_out_ready, bus.osif_write}), 64'd0);
            check("reset_strb", 64'(bus.osif_strb_din), 64'hFF);
            @(negedge aclk);
            @(negedge aclk);
            aresetn = 1'b1;
            fifo_d.delete(); fifo_l.delete(); core_q.delete(); expq.delete();
            abort_now = 1'b0; abort_after = 0; err_chk = 1'b0; stall = 1'b0;
            @(posedge aclk);
            #1;
            return;
        end
        check("done_seen", 64'(done_seen), 64'd1);
        tick();
        check("idle_after_done", 64'(busy), 64'd0);
        check("read_count", 64'(rd_cnt), 64'(in_n));
        check("write_count", 64'(wr_cnt), 64'(out_n));
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("scoreboard_empty", 64'(expq.size()), 64'd0);
        check("err_final", 64'(err_len), 64'(exp_err));
        if (exp_busy != 0) check("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
        if (chk_t) check("done_after_last_write", 64'(done_cyc - last_wr_cyc), 64'd1);
        core_q.delete(); fifo_d.delete(); fifo_l.delete(); expq.delete();
        hold = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        stall = 1'b0; hold = 1'b0; err_chk = 1'b0; err_model = 1'b0;
        done_seen = 1'b0; abort_now = 1'b0; abort_after = 0;
        bus.isif_empty_n = 1'b1; bus.isif_data_dout = '0; bus.isif_last_dout = 1'b0;
        bus.isif_strb_dout = '0; bus.core_in_ready = 1'b1; bus.core_out_valid = 1'b1;
        bus.core_out_data = '0; bus.osif_full_n = 1'b1;
        #12;
        check("init_reset_outputs", 64'({busy, done, err_len, bus.isif_read, bus.core_in_valid,
                                         bus.core_out_ready, bus.osif_write}), 64'd0);
        check("init_reset_strb", 64'(bus.osif_strb_din), 64'hFF);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        //       in out g  lastp st    hd    err   busy chk_t ab
        run_job(4, 2, 2, -1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 0);
        run_job(8, 8, 1, -1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
        run_job(4, 2, 2,  1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0);
        run_job(0, 0, 1, -1, 1'b0, 1'b0, 1'b0, 2, 1'b0, 0);
        run_job(3, 0, 1, -1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        run_job(4, 2, 2, -1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0);
        run_job(8, 8, 1, -1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
        run_job(5, 5, 1, -1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 2);
        run_job(5, 5, 1, -1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
